// File: rtl/ahb_manager_mux.sv
// Bus-ownership FSM and AHB signal mux sitting behind the round-robin arbiter.
// Request-to-first-address-phase is 3 cycles; non-owners see m_hready low until served.
module ahb_manager_mux #(
  parameter int MANAGERS = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [MANAGERS-1:0]          m_req,
  input  logic [MANAGERS*ADDR_W-1:0]   m_haddr,
  input  logic [MANAGERS*2-1:0]        m_htrans,
  input  logic [MANAGERS-1:0]          m_hwrite,
  input  logic [MANAGERS*3-1:0]        m_hsize,
  input  logic [MANAGERS*3-1:0]        m_hburst,
  input  logic [MANAGERS*DATA_W-1:0]   m_hwdata,
  output logic [MANAGERS-1:0]          m_hready,
  output logic [DATA_W-1:0]            m_hrdata,
  output logic                         m_hresp,
  output logic                         arb_en,
  input  logic [MANAGERS-1:0]          arb_grant,
  output logic [ADDR_W-1:0]            HADDR,
  output logic [1:0]                   HTRANS,
  output logic                         HWRITE,
  output logic [2:0]                   HSIZE,
  output logic [2:0]                   HBURST,
  output logic [DATA_W-1:0]            HWDATA,
  input  logic                         HREADY,
  input  logic [DATA_W-1:0]            HRDATA,
  input  logic                         HRESP,
  output logic [$clog2(MANAGERS)-1:0]  owner_id,
  output logic                         owner_valid,
  output logic                         grant_err
);

  localparam int ID_W = $clog2(MANAGERS);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT, S_OWN} state_t;

  state_t           state_q, state_d;
  logic             arb_en_q, arb_en_d;
  logic             grant_err_q, grant_err_d;
  logic             data_valid_q, data_valid_d;
  logic [ID_W-1:0]  owner_id_q, owner_id_d;
  logic [ID_W-1:0]  data_owner_q, data_owner_d;

  logic             grant_any;
  logic             grant_onehot;
  logic [ID_W-1:0]  grant_idx;
  logic [1:0]       own_htrans;
  logic             own_req;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < MANAGERS; i++) begin
      if (arb_grant[i]) grant_idx = ID_W'(i);
    end
  end

  // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
  assign grant_any    = |arb_grant;
  assign grant_onehot = grant_any &&
                        ((arb_grant & (arb_grant - {{(MANAGERS-1){1'b0}}, 1'b1})) == '0);

  assign own_htrans = m_htrans[int'(owner_id_q)*2 +: 2];
  assign own_req    = m_req[owner_id_q];

  always_comb begin
    state_d      = state_q;
    owner_id_d   = owner_id_q;
    data_owner_d = data_owner_q;
    data_valid_d = data_valid_q;
    grant_err_d  = 1'b0;

    case (state_q)
      S_IDLE: if (|m_req) state_d = S_ARB;
      S_ARB:  state_d = S_WAIT;
      S_WAIT: begin
        if (grant_onehot && m_req[grant_idx]) begin
          state_d    = S_OWN;
          owner_id_d = grant_idx;
        end else begin
          state_d     = S_IDLE;
          grant_err_d = grant_any && !grant_onehot;
        end
      end
      S_OWN: begin
        if (HREADY && (own_htrans == 2'b00 || !own_req)) begin
          state_d = (|m_req) ? S_ARB : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (HREADY) begin
      if (state_q == S_OWN) begin
        data_owner_d = owner_id_q;
        data_valid_d = own_htrans[1];
      end else begin
        data_valid_d = 1'b0;
      end
    end
  end

  assign arb_en_d = (state_d == S_ARB);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      arb_en_q     <= 1'b0;
      owner_id_q   <= '0;
      data_owner_q <= '0;
      data_valid_q <= 1'b0;
      grant_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      arb_en_q     <= arb_en_d;
      owner_id_q   <= owner_id_d;
      data_owner_q <= data_owner_d;
      data_valid_q <= data_valid_d;
      grant_err_q  <= grant_err_d;
    end
  end

  assign owner_valid = (state_q == S_OWN);
  assign owner_id    = owner_id_q;
  assign arb_en      = arb_en_q;
  assign grant_err   = grant_err_q;

  assign HADDR  = owner_valid ? m_haddr[int'(owner_id_q)*ADDR_W +: ADDR_W] : '0;
  assign HTRANS = owner_valid ? own_htrans : 2'b00;
  assign HWRITE = owner_valid ? m_hwrite[owner_id_q] : 1'b0;
  assign HSIZE  = owner_valid ? m_hsize[int'(owner_id_q)*3 +: 3] : 3'b000;
  assign HBURST = owner_valid ? m_hburst[int'(owner_id_q)*3 +: 3] : 3'b000;

  assign HWDATA = data_valid_q ? m_hwdata[int'(data_owner_q)*DATA_W +: DATA_W] : '0;

  always_comb begin
    for (int i = 0; i < MANAGERS; i++) begin
      m_hready[i] = HREADY & ((owner_valid  & (owner_id_q   == ID_W'(i))) |
                              (data_valid_q & (data_owner_q == ID_W'(i))));
    end
  end

  assign m_hrdata = HRDATA;
  assign m_hresp  = HRESP;

endmodule

// File: tb/tb_ahb_manager_mux.sv
// Directed bench for ahb_manager_mux: arbitration, bursts, stalls, handover, bad grant, reset.
module tb_ahb_manager_mux;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [3:0]   m_req;
  logic [127:0] m_haddr;
  logic [7:0]   m_htrans;
  logic [3:0]   m_hwrite;
  logic [11:0]  m_hsize;
  logic [11:0]  m_hburst;
  logic [127:0] m_hwdata;
  logic [3:0]   m_hready;
  logic [31:0]  m_hrdata;
  logic         m_hresp;
  logic         arb_en;
  logic [3:0]   arb_grant;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic [2:0]   HBURST;
  logic [31:0]  HWDATA;
  logic         HREADY;
  logic [31:0]  HRDATA;
  logic         HRESP;
  logic [1:0]   owner_id;
  logic         owner_valid;
  logic         grant_err;

  logic [31:0] ad [4];
  logic [1:0]  tr [4];
  logic        wr [4];
  logic [2:0]  sz [4];
  logic [2:0]  bu [4];
  logic [31:0] wd [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      m_haddr[i*32 +: 32]  = ad[i];
      m_htrans[i*2 +: 2]   = tr[i];
      m_hwrite[i]          = wr[i];
      m_hsize[i*3 +: 3]    = sz[i];
      m_hburst[i*3 +: 3]   = bu[i];
      m_hwdata[i*32 +: 32] = wd[i];
    end
  end

  ahb_manager_mux #(.MANAGERS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m_req(m_req), .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
    .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
    .m_hready(m_hready), .m_hrdata(m_hrdata), .m_hresp(m_hresp),
    .arb_en(arb_en), .arb_grant(arb_grant),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP),
    .owner_id(owner_id), .owner_valid(owner_valid), .grant_err(grant_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESET = 1'b1;
    m_req = 4'b0000;
    arb_grant = 4'b0000;
    HREADY = 1'b1;
    HRDATA = 32'h0;
    HRESP = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ad[i] = 32'hA000_0000 + 32'(i) * 32'h100;
      tr[i] = 2'b00;
      wr[i] = 1'b0;
      sz[i] = 3'b010;
      bu[i] = 3'b000;
      wd[i] = 32'hD000_0000 + 32'(i);
    end
    step();
    step();

    // reset state
    chk("rst_arb_en", arb_en, 0);
    chk("rst_owner_valid", owner_valid, 0);
    chk("rst_owner_id", owner_id, 0);
    chk("rst_grant_err", grant_err, 0);
    chk("rst_htrans", HTRANS, 0);
    chk("rst_m_hready", m_hready, 4'b0000);
    chk("rst_hwdata", HWDATA, 0);

    // manager 0 requests; arbiter grant presented
    HRESET = 1'b0;
    m_req = 4'b0001;
    arb_grant = 4'b0001;
    tr[0] = 2'b10;
    step();                                        // ARB
    chk("m0_arb_en", arb_en, 1);
    chk("m0_arb_htrans", HTRANS, 0);
    step();                                        // WAIT
    chk("m0_wait_arb_en", arb_en, 0);
    chk("m0_wait_owner_valid", owner_valid, 0);
    HRDATA = 32'h1234_5678;
    HRESP = 1'b1;
    step();                                        // OWN m0
    chk("m0_owner_valid", owner_valid, 1);
    chk("m0_owner_id", owner_id, 0);
    chk("m0_haddr", HADDR, 32'hA000_0000);
    chk("m0_htrans", HTRANS, 2'b10);
    chk("m0_m_hready", m_hready, 4'b0001);
    chk("m0_hwdata_idle", HWDATA, 0);
    chk("hrdata_pass", m_hrdata, 32'h1234_5678);
    chk("hresp_pass", m_hresp, 1);
    HRESP = 1'b0;
    step();                                        // data phase of m0 beat
    chk("m0_hwdata", HWDATA, 32'hD000_0000);
    chk("m0_m_hready2", m_hready, 4'b0001);
    tr[0] = 2'b00;
    m_req = 4'b0010;
    arb_grant = 4'b0010;
    tr[1] = 2'b10; ad[1] = 32'hB000_0000; wr[1] = 1'b1; bu[1] = 3'b011;
    step();                                        // ARB after release
    chk("rel_arb_en", arb_en, 1);
    chk("rel_owner_valid", owner_valid, 0);
    chk("rel_m_hready", m_hready, 4'b0000);
    chk("rel_hwdata", HWDATA, 0);
    m_req = 4'b0011;
    step();                                        // WAIT
    chk("m1_wait_htrans", HTRANS, 0);
    step();                                        // OWN m1, INCR4 beat 0
    chk("m1_owner_id", owner_id, 1);
    chk("m1_haddr0", HADDR, 32'hB000_0000);
    chk("m1_htrans0", HTRANS, 2'b10);
    chk("m1_hburst", HBURST, 3'b011);
    chk("m1_hwrite", HWRITE, 1);
    chk("m1_m_hready0", m_hready, 4'b0010);
    tr[1] = 2'b11; ad[1] = 32'hB000_0004;
    step();                                        // beat 1
    chk("m1_htrans1", HTRANS, 2'b11);
    chk("m1_haddr1", HADDR, 32'hB000_0004);
    chk("m1_hwdata1", HWDATA, 32'hD000_0001);
    chk("m1_m_hready1", m_hready, 4'b0010);
    ad[1] = 32'hB000_0008;
    step();                                        // beat 2
    chk("m1_owner_id2", owner_id, 1);
    chk("m1_m_hready2", m_hready, 4'b0010);
    ad[1] = 32'hB000_000C;
    step();                                        // beat 3
    chk("m1_haddr3", HADDR, 32'hB000_000C);
    HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin              // subordinate stalls 3 cycles
      step();
      chk("stall_haddr", HADDR, 32'hB000_000C);
      chk("stall_owner_id", owner_id, 1);
      chk("stall_owner_valid", owner_valid, 1);
      chk("stall_m_hready", m_hready, 4'b0000);
      chk("stall_hwdata", HWDATA, 32'hD000_0001);
    end
    HREADY = 1'b1;
    step();                                        // beat 3 completed, data phase
    chk("m1_held_after_burst", owner_valid, 1);
    chk("m1_hwdata3", HWDATA, 32'hD000_0001);
    tr[1] = 2'b00;
    m_req = 4'b0100;
    arb_grant = 4'b0100;
    tr[2] = 2'b10; ad[2] = 32'hC000_0000; wr[2] = 1'b1;
    step();                                        // ARB
    chk("m1_rel_arb_en", arb_en, 1);
    chk("m1_rel_m_hready", m_hready, 4'b0000);
    step();                                        // WAIT
    step();                                        // OWN m2
    chk("m2_owner_id", owner_id, 2);
    chk("m2_haddr", HADDR, 32'hC000_0000);
    chk("m2_hwdata_none", HWDATA, 0);
    m_req = 4'b0001;                               // m2 drops req on its last beat
    arb_grant = 4'b0110;
    step();                                        // ARB, m2 data phase pending
    chk("ho_arb_en", arb_en, 1);
    chk("ho_owner_valid", owner_valid, 0);
    chk("ho_htrans", HTRANS, 0);
    chk("ho_hwdata", HWDATA, 32'hD000_0002);
    chk("ho_m_hready", m_hready, 4'b0100);
    step();                                        // WAIT with multi-hot grant
    chk("ho_wait_hwdata", HWDATA, 0);
    chk("ho_wait_m_hready", m_hready, 4'b0000);
    step();                                        // IDLE + grant_err
    chk("gerr_pulse", grant_err, 1);
    chk("gerr_owner_valid", owner_valid, 0);
    chk("gerr_htrans", HTRANS, 0);
    chk("gerr_arb_en", arb_en, 0);
    arb_grant = 4'b0001;
    tr[0] = 2'b10; bu[0] = 3'b001;
    step();                                        // re-arbitration
    chk("gerr_clear", grant_err, 0);
    chk("rearb_arb_en", arb_en, 1);
    step();                                        // WAIT
    step();                                        // OWN m0
    chk("m0b_owner_valid", owner_valid, 1);
    chk("m0b_hburst", HBURST, 3'b001);
    tr[0] = 2'b11; ad[0] = 32'hA000_0004;
    step();                                        // mid-burst
    chk("m0b_htrans", HTRANS, 2'b11);
    chk("m0b_hwdata", HWDATA, 32'hD000_0000);
    HRESET = 1'b1;
    step();                                        // reset mid-burst
    chk("mrst_arb_en", arb_en, 0);
    chk("mrst_owner_valid", owner_valid, 0);
    chk("mrst_owner_id", owner_id, 0);
    chk("mrst_htrans", HTRANS, 0);
    chk("mrst_haddr", HADDR, 0);
    chk("mrst_hwdata", HWDATA, 0);
    chk("mrst_m_hready", m_hready, 4'b0000);
    chk("mrst_grant_err", grant_err, 0);
    HRESET = 1'b0;
    m_req = 4'b0000;
    step();
    chk("post_rst_idle_arb_en", arb_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
